// File: rtl/add_mux_pipe.sv
// rtl/add_mux_pipe.sv - two-stage pipelined half-word adder with upper-half select mux and valid/ready flow control
module add_mux_pipe #(
    parameter int WIDTH = 8,
    parameter int SAT   = 0,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic             sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             overflow,
    output logic             busy,
    output logic [CNT_W-1:0] txn_count
);
    localparam int H = WIDTH / 2;

    logic         s1_valid;
    logic         s2_valid;
    logic [H:0]   s1_sum;
    logic [H-1:0] s1_a;
    logic         s1_sel;

    logic         s1_advance;
    logic         in_fire;
    logic [H:0]   sum_in;
    logic [H-1:0] low_next;
    logic [H-1:0] upper_next;

    // S1 may hand its beat to S2 when S2 is empty or draining this cycle
    assign s1_advance = s1_valid && (!s2_valid || out_ready);
    assign in_ready   = !rst && (!s1_valid || s1_advance);
    assign in_fire    = in_valid && in_ready;
    assign sum_in     = {1'b0, data_in[H-1:0]} + {1'b0, data_in[WIDTH-1:H]};

    always_comb begin
        low_next = s1_sum[H-1:0];
        if (SAT != 0 && s1_sum[H]) begin
            low_next = '1;
        end
        upper_next = s1_sel ? s1_a : '0;
    end

    assign out_valid = s2_valid;
    assign busy      = s1_valid || s2_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s1_sum    <= '0;
            s1_a      <= '0;
            s1_sel    <= 1'b0;
            data_out  <= '0;
            overflow  <= 1'b0;
            txn_count <= '0;
        end else begin
            if (s1_advance) begin
                s2_valid <= 1'b1;
                data_out <= {upper_next, low_next};
                overflow <= s1_sum[H];
            end else if (s2_valid && out_ready) begin
                s2_valid <= 1'b0;
            end

            if (in_fire) begin
                s1_valid  <= 1'b1;
                s1_sum    <= sum_in;
                s1_a      <= data_in[H-1:0];
                s1_sel    <= sel;
                txn_count <= txn_count + CNT_W'(1);
            end else if (s1_advance) begin
                s1_valid <= 1'b0;
            end
        end
    end
endmodule
